// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock qualified, staged reset release controller.
// Filters and synchronises PLL lock, holds every reset domain for HOLD_CYCLES,
// then releases rst_out[0] .. rst_out[NUM_RST-1] in order, STAGE_GAP cycles apart.
// Lock loss (after qualification) or a software request in RUN restarts the sequence.
// Optional feature: define RESET_SEQ_WDT_EN to add the RUN-state watchdog
// (ports wdt_kick / wdt_fired).
module reset_sequencer #(
  parameter int unsigned NUM_RST     = 2,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 256,
  parameter int unsigned WDT_CYCLES  = 1048576
) (
  input  logic               wb_clk,
  input  logic               io_resetn,
  input  logic               lock,
  input  logic               sw_rst_req,
`ifdef RESET_SEQ_WDT_EN
  input  logic               wdt_kick,
  output logic               wdt_fired,
`endif
  output logic [NUM_RST-1:0] rst_out,
  output logic               rst_done,
  output logic               lock_lost
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);

  localparam logic [NUM_RST-1:0] ALL_ON    = '1;
  localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [1:0]         rst_sync;
  logic               rst_released;
  logic               lock_meta;
  logic               lock_s;
  logic               lock_loss;
  logic               restart_req;

  state_t             state, state_n;
  logic [FILT_W-1:0]  filt_cnt, filt_cnt_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [NUM_RST-1:0] rst_out_n;
  logic               rst_done_n;
  logic               lock_lost_n;

  // Release of io_resetn is synchronised; its assertion stays asynchronous.
  always_ff @(posedge wb_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_released = rst_sync[1];

  // Two-flop synchroniser bringing the asynchronous PLL lock into wb_clk.
  always_ff @(posedge wb_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  // A drop of lock only counts once lock has been qualified (HOLD onwards).
  assign lock_loss = !lock_s &&
                     ((state == ST_HOLD) || (state == ST_RELEASE) || (state == ST_RUN));

`ifdef RESET_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt, wdt_cnt_n;
  logic             wdt_fired_n;
  logic             wdt_expire;

  // The watchdog expires on the edge where its count would reach WDT_CYCLES unkicked.
  assign wdt_expire  = (state == ST_RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);
  assign restart_req = sw_rst_req || wdt_expire;

  // Watchdog counter and its sticky timeout flag.
  always_ff @(posedge wb_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      wdt_cnt   <= wdt_cnt_n;
      wdt_fired <= wdt_fired_n;
    end
  end
`else
  // WDT_CYCLES stays in the parameter list so both builds share one interface.
  if (WDT_CYCLES == 0) begin : g_wdt_disabled
  end

  assign restart_req = sw_rst_req;
`endif

  // FSM state, counters and registered reset outputs.
  always_ff @(posedge wb_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      state     <= ST_RESET;
      filt_cnt  <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rst_out   <= ALL_ON;
      rst_done  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      filt_cnt  <= filt_cnt_n;
      hold_cnt  <= hold_cnt_n;
      gap_cnt   <= gap_cnt_n;
      rst_out   <= rst_out_n;
      rst_done  <= rst_done_n;
      lock_lost <= lock_lost_n;
    end
  end

  // Next-state and output decode; counters idle at zero outside their own state,
  // and a qualified lock loss overrides every other decision.
  always_comb begin
    state_n     = state;
    filt_cnt_n  = '0;
    hold_cnt_n  = '0;
    gap_cnt_n   = '0;
    rst_out_n   = rst_out;
    rst_done_n  = rst_done;
    lock_lost_n = lock_lost;
`ifdef RESET_SEQ_WDT_EN
    wdt_cnt_n   = '0;
    wdt_fired_n = wdt_fired;
`endif

    unique case (state)
      ST_RESET: begin
        rst_out_n  = ALL_ON;
        rst_done_n = 1'b0;
        if (rst_released) begin
          state_n = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        rst_out_n  = ALL_ON;
        rst_done_n = 1'b0;
        if (lock_s) begin
          if (filt_cnt == FILT_LAST) begin
            state_n = ST_HOLD;
          end else begin
            filt_cnt_n = filt_cnt + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        rst_out_n  = ALL_ON;
        rst_done_n = 1'b0;
        if (hold_cnt == HOLD_LAST) begin
          rst_out_n = ALL_ON << 1;
          if (rst_out_n == '0) begin
            state_n    = ST_RUN;
            rst_done_n = 1'b1;
          end else begin
            state_n = ST_RELEASE;
          end
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (gap_cnt == GAP_LAST) begin
          rst_out_n = rst_out << 1;
          if (rst_out_n == '0) begin
            state_n    = ST_RUN;
            rst_done_n = 1'b1;
          end
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        rst_out_n  = '0;
        rst_done_n = 1'b1;
`ifdef RESET_SEQ_WDT_EN
        if (!wdt_kick) begin
          wdt_cnt_n = wdt_cnt + 1'b1;
        end
        if (wdt_expire) begin
          wdt_fired_n = 1'b1;
        end
`endif
        if (restart_req) begin
          state_n    = ST_HOLD;
          rst_out_n  = ALL_ON;
          rst_done_n = 1'b0;
`ifdef RESET_SEQ_WDT_EN
          wdt_cnt_n  = '0;
`endif
        end
      end

      default: begin
        state_n    = ST_RESET;
        rst_out_n  = ALL_ON;
        rst_done_n = 1'b0;
      end
    endcase

    if (lock_loss) begin
      state_n     = ST_WAIT_LOCK;
      filt_cnt_n  = '0;
      hold_cnt_n  = '0;
      gap_cnt_n   = '0;
      rst_out_n   = ALL_ON;
      rst_done_n  = 1'b0;
      lock_lost_n = 1'b1;
`ifdef RESET_SEQ_WDT_EN
      wdt_cnt_n   = '0;
      wdt_fired_n = wdt_fired;
`endif
    end
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller between the PLL and the SoC. It filters and synchronises PLL `lock`, holds all reset domains for a programmable time, then releases N active-high reset outputs one by one in order. It re-enters reset on lock loss or on a software request. It replaces the single-flop `!lock` reset at top level and drives `wb_rst` plus later peripheral domains.

## Interface
Parameters:
- `NUM_RST`, 2: number of reset outputs, 1..8.
- `LOCK_FILTER`, 16: consecutive synchronised-lock-high cycles required, ≥1.
- `HOLD_CYCLES`, 1024: cycles all resets stay asserted after lock qualifies, ≥1.
- `STAGE_GAP`, 256: cycles between successive `rst_out` releases, ≥1.
- `WDT_CYCLES`, 1048576: watchdog timeout; used only with `RESET_SEQ_WDT_EN`.

Ports:
- `wb_clk` in 1: single clock (PLL output).
- `io_resetn` in 1: asynchronous, active-low reset.
- `lock` in 1: PLL lock, asynchronous to `wb_clk`.
- `sw_rst_req` in 1: synchronous one-cycle software reset request.
- `rst_out` out NUM_RST: active-high resets; bit 0 is released first.
- `rst_done` out 1: high when all `rst_out` are deasserted.
- `lock_lost` out 1: sticky flag for a lock drop after qualification.
- `wdt_kick` in 1: watchdog service pulse (only with macro).
- `wdt_fired` out 1: sticky watchdog-timeout flag (only with macro).

## Operation
- Reset values: `rst_out` all ones, `rst_done`=0, `lock_lost`=0, `wdt_fired`=0, state RESET.
- `io_resetn` low asserts all outputs to their reset values immediately, without a clock edge. Release goes through a 2-flop synchroniser; RESET→WAIT_LOCK on the first edge after the synchronised release.
- `lock` goes through a 2-flop synchroniser to give `lock_s`. All decisions use `lock_s`.
- States:
  - RESET
  - WAIT_LOCK: `rst_out` all ones.
    - Filter counter increments while `lock_s`=1 and clears when `lock_s`=0.
    - Goes to HOLD on the edge where the count reaches `LOCK_FILTER`.
    - A lock drop here does not set `lock_lost`.
  - HOLD: `rst_out` all ones. Counter runs `HOLD_CYCLES` cycles, then goes to RELEASE.
  - RELEASE: clears `rst_out[0]` on entry. Clears bit i+1 `STAGE_GAP` cycles after bit i.
  - RUN: entered on the same edge that clears `rst_out[NUM_RST-1]`. `rst_done`=1 from that edge on.
- `lock_s`=0 in HOLD, RELEASE or RUN:
  - Next edge: `rst_out` all ones, `rst_done`=0, `lock_lost`=1, state WAIT_LOCK with the filter counter cleared.
- `sw_rst_req`=1 in RUN:
  - Next edge: `rst_out` all ones, `rst_done`=0, state HOLD with the counter cleared. `lock_lost` is unchanged.
  - Ignored in all other states.
- Simultaneous lock loss and `sw_rst_req`: lock loss wins.
- `lock_lost` and `wdt_fired` clear only on `io_resetn`.
- Counter widths: `$clog2(max+1)` of their respective parameter. Counters never wrap; each clears on a state change.

## Timing
- `lock` to `lock_s`: 2 cycles.
- With `lock_s` continuously high from edge T in WAIT_LOCK:
  - HOLD entered at T+`LOCK_FILTER`.
  - `rst_out[0]` falls at T+`LOCK_FILTER`+`HOLD_CYCLES`.
  - `rst_out[i]` falls i×`STAGE_GAP` cycles after `rst_out[0]`.
  - `rst_done` rises with the last bit.
- Re-assertion on lock loss or `sw_rst_req`: 1 cycle after `lock_s`=0 or the request edge.
- Re-assertion on `io_resetn` low: combinational (asynchronous).
- All outputs are registered. Every `rst_out` bit asserts together.

## Configuration
- `RESET_SEQ_WDT_EN` defined: adds the watchdog and ports `wdt_kick`/`wdt_fired`.
  - In RUN a counter counts cycles since entry or since the last `wdt_kick`.
  - When the counter reaches `WDT_CYCLES`: behaves as `sw_rst_req`, and sets `wdt_fired`=1.
  - The counter is held at zero outside RUN.
- Not defined: no watchdog logic and no `wdt_kick`/`wdt_fired` ports. Behaviour is otherwise identical.

## Test plan
Parameters for all scenarios: `NUM_RST`=3, `LOCK_FILTER`=4, `HOLD_CYCLES`=8, `STAGE_GAP`=2.
- Power-up: `io_resetn` low 5 cycles then high, `lock` high → `rst_out`=111 throughout reset. Counting from the first `lock_s`=1 edge in WAIT_LOCK: `rst_out[0]` falls at +12, `[1]` at +14, `[2]` and `rst_done` at +16, `lock_lost`=0.
- Lock glitch in WAIT_LOCK: `lock_s` high 3 cycles, low 1, then high → filter restarts. `rst_out[0]` falls 12 cycles after the second rise; `lock_lost` stays 0.
- Lock loss in RUN: `lock` low 1 cycle → `rst_out`=111 and `rst_done`=0 on the edge after `lock_s`=0, `lock_lost`=1. Full sequence repeats on relock; `lock_lost` stays 1.
- `sw_rst_req` pulse in RUN → next edge `rst_out`=111; `rst_out[0]` falls 8 cycles later; `lock_lost` unchanged.
- `sw_rst_req` during RELEASE → ignored, release timing unchanged.
- `io_resetn` pulled low between clock edges mid-RELEASE → `rst_out`=111 with no edge, sticky flags cleared.
- With `RESET_SEQ_WDT_EN`, `WDT_CYCLES`=10:
  - No kicks → HOLD entered 10 cycles after RUN entry, `wdt_fired`=1.
  - Kick every 5 cycles → stays in RUN for 100 cycles.
